// File: rtl/game_pkg.sv
// Shared types and constants for the 2048 game sequencer.
// Optional feature macro: WIN_DETECT_EN (enables the 2048 win check).
package game_pkg;

  localparam int N = 4;
  localparam int TILE_W = 4;
  localparam int WIN_TILE = 11;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // A tile stores the exponent n of 2^n; 0 is an empty cell.
  typedef logic [TILE_W-1:0] tile_t;
  // One row or column, element 0 is the tile nearest the move edge.
  typedef tile_t [0:N-1] line_t;
  // Board addressed as board[row][col].
  typedef line_t [0:N-1] board_t;

  typedef enum logic [1:0] {RIGHT, LEFT, UP, DOWN} dir_t;

  typedef enum logic [2:0] {
    WAIT_START,
    IDLE,
    SLIDE,
    SPAWN,
    CHECK,
    LOST,
    WON
  } state_t;

  // Merged tile value, pinned at the largest encodable exponent.
  function automatic tile_t tile_inc(tile_t t);
    return (t == '1) ? t : t + tile_t'(1);
  endfunction

  // 16-bit Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Button inputs and board/status outputs of the game sequencer.
interface game_sequencer_if;
  import game_pkg::*;

  logic   mov_right;
  logic   mov_left;
  logic   mov_up;
  logic   mov_down;
  board_t matrix;
  logic   defeat;
  logic   win;
  logic   busy;

  modport master (
    output mov_right, mov_left, mov_up, mov_down,
    input  matrix, defeat, win, busy
  );

  modport slave (
    input  mov_right, mov_left, mov_up, mov_down,
    output matrix, defeat, win, busy
  );

endinterface

// File: rtl/line_merge.sv
// Combinational slide of one line toward element 0: compress, merge
// equal neighbours once, compress again.
module line_merge
  import game_pkg::*;
(
  input  line_t line_in,
  output line_t line_out,
  output logic  changed
);

  line_t      comp;
  line_t      merged;
  logic [2:0] wr_idx;

  // Compress, merge once per pair, re-compress, then flag any difference
  always_comb begin
    comp     = '0;
    merged   = '0;
    line_out = '0;
    wr_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (line_in[i] != '0) begin
        comp[wr_idx[1:0]] = line_in[i];
        wr_idx = wr_idx + 3'd1;
      end
    end
    merged = comp;
    // A merged pair leaves a zero behind it, so it cannot merge again
    for (int i = 0; i < N - 1; i++) begin
      if (merged[i] != '0 && merged[i] == merged[i+1]) begin
        merged[i]   = tile_inc(merged[i]);
        merged[i+1] = '0;
      end
    end
    wr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (merged[i] != '0) begin
        line_out[wr_idx[1:0]] = merged[i];
        wr_idx = wr_idx + 3'd1;
      end
    end
    changed = (line_out != line_in);
  end

endmodule

// File: rtl/game_sequencer.sv
// 2048 game sequencer: button edge detection, line-by-line slide,
// random tile spawn and end-of-game check.
// Optional feature macro: WIN_DETECT_EN (stop with win=1 on a 2048 tile).
module game_sequencer
  import game_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  game_sequencer_if.slave gif
);

  state_t      state_q, state_d;
  board_t      board_q, board_d;
  dir_t        dir_q, dir_d;
  logic [1:0]  line_q, line_d;
  logic        moved_q, moved_d;
  logic [3:0]  scan_q, scan_d;
  logic [3:0]  scan_cnt_q, scan_cnt_d;
  logic        second_q, second_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  btn_q, btn_d;
  logic        defeat_q, defeat_d;
  logic        busy_q, busy_d;
`ifdef WIN_DETECT_EN
  logic        win_q, win_d;
  logic        any_win;
`endif

  logic [3:0]  btn_raw;
  logic [3:0]  press;
  logic        press_any;
  dir_t        press_dir;
  line_t       line_in;
  line_t       line_out;
  logic        line_changed;
  logic        any_empty;
  logic        any_pair;

  // Bit order {right, left, up, down}; buttons idle high
  assign btn_raw   = {gif.mov_right, gif.mov_left, gif.mov_up, gif.mov_down};
  assign press     = btn_q & ~btn_raw;
  assign press_any = |press;

  // Pick one direction when several buttons go down together
  always_comb begin
    if (press[3])      press_dir = RIGHT;
    else if (press[2]) press_dir = LEFT;
    else if (press[1]) press_dir = UP;
    else               press_dir = DOWN;
  end

  // Gather the active line with the tile nearest the move edge first
  always_comb begin
    line_in = '0;
    for (int i = 0; i < N; i++) begin
      case (dir_q)
        RIGHT:   line_in[i] = board_q[line_q][N-1-i];
        LEFT:    line_in[i] = board_q[line_q][i];
        UP:      line_in[i] = board_q[i][line_q];
        DOWN:    line_in[i] = board_q[N-1-i][line_q];
        default: line_in[i] = board_q[line_q][i];
      endcase
    end
  end

  line_merge u_line_merge (
    .line_in  (line_in),
    .line_out (line_out),
    .changed  (line_changed)
  );

  // Board-wide status used by CHECK
  always_comb begin
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (board_q[r][c] == '0) any_empty = 1'b1;
      end
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N - 1; c++) begin
        if (board_q[r][c] != '0 && board_q[r][c] == board_q[r][c+1]) any_pair = 1'b1;
      end
    end
    for (int r = 0; r < N - 1; r++) begin
      for (int c = 0; c < N; c++) begin
        if (board_q[r][c] != '0 && board_q[r][c] == board_q[r+1][c]) any_pair = 1'b1;
      end
    end
  end

`ifdef WIN_DETECT_EN
  // Any cell holding the winning exponent
  always_comb begin
    any_win = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (board_q[r][c] == tile_t'(WIN_TILE)) any_win = 1'b1;
      end
    end
  end
`endif

  // Next-state, board update and next registered outputs
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    dir_d      = dir_q;
    line_d     = line_q;
    moved_d    = moved_q;
    scan_d     = scan_q;
    scan_cnt_d = scan_cnt_q;
    second_d   = second_q;
    defeat_d   = defeat_q;
`ifdef WIN_DETECT_EN
    win_d      = win_q;
`endif
    lfsr_d     = lfsr_next(lfsr_q);
    btn_d      = btn_raw;

    case (state_q)
      WAIT_START: begin
        // First press seeds the board with two tiles, no slide
        if (press_any) begin
          state_d    = SPAWN;
          scan_d     = lfsr_q[3:0];
          scan_cnt_d = '0;
          second_d   = 1'b1;
        end
      end
      IDLE: begin
        if (press_any) begin
          state_d = SLIDE;
          dir_d   = press_dir;
          line_d  = '0;
          moved_d = 1'b0;
        end
      end
      SLIDE: begin
        for (int i = 0; i < N; i++) begin
          case (dir_q)
            RIGHT:   board_d[line_q][N-1-i] = line_out[i];
            LEFT:    board_d[line_q][i]     = line_out[i];
            UP:      board_d[i][line_q]     = line_out[i];
            DOWN:    board_d[N-1-i][line_q] = line_out[i];
            default: board_d[line_q][i]     = line_out[i];
          endcase
        end
        moved_d = moved_q | line_changed;
        line_d  = line_q + 2'd1;
        if (line_q == 2'(N - 1)) begin
          if (moved_d) begin
            state_d    = SPAWN;
            scan_d     = lfsr_q[3:0];
            scan_cnt_d = '0;
            second_d   = 1'b0;
          end else begin
            state_d = CHECK;
          end
        end
      end
      SPAWN: begin
        if (board_q[scan_q[3:2]][scan_q[1:0]] == '0) begin
          board_d[scan_q[3:2]][scan_q[1:0]] = tile_t'(1);
          if (second_q) begin
            second_d   = 1'b0;
            scan_d     = lfsr_q[3:0];
            scan_cnt_d = '0;
          end else begin
            state_d = CHECK;
          end
        end else if (scan_cnt_q == 4'd15) begin
          // Full board: nowhere to place a tile
          state_d = CHECK;
        end else begin
          scan_d     = scan_q + 4'd1;
          scan_cnt_d = scan_cnt_q + 4'd1;
        end
      end
      CHECK: begin
`ifdef WIN_DETECT_EN
        if (any_win) begin
          win_d   = 1'b1;
          state_d = WON;
        end else
`endif
        if (!any_empty && !any_pair) begin
          defeat_d = 1'b1;
          state_d  = LOST;
        end else begin
          state_d = IDLE;
        end
      end
      LOST:    state_d = LOST;
      WON:     state_d = WON;
      default: state_d = WAIT_START;
    endcase

    busy_d = (state_d == SLIDE) || (state_d == SPAWN) || (state_d == CHECK);
  end

  // Register state, board and outputs; active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= WAIT_START;
      board_q    <= '0;
      dir_q      <= RIGHT;
      line_q     <= '0;
      moved_q    <= 1'b0;
      scan_q     <= '0;
      scan_cnt_q <= '0;
      second_q   <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      btn_q      <= '1;
      defeat_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef WIN_DETECT_EN
      win_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      dir_q      <= dir_d;
      line_q     <= line_d;
      moved_q    <= moved_d;
      scan_q     <= scan_d;
      scan_cnt_q <= scan_cnt_d;
      second_q   <= second_d;
      lfsr_q     <= lfsr_d;
      btn_q      <= btn_d;
      defeat_q   <= defeat_d;
      busy_q     <= busy_d;
`ifdef WIN_DETECT_EN
      win_q      <= win_d;
`endif
    end
  end

  assign gif.matrix = board_q;
  assign gif.defeat = defeat_q;
  assign gif.busy   = busy_q;
`ifdef WIN_DETECT_EN
  assign gif.win    = win_q;
`else
  assign gif.win    = 1'b0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer and its line_merge helper.
module tb_game_sequencer;
  import game_pkg::*;

  localparam int WINDOW = 60;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  game_sequencer_if gif();

  game_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .gif   (gif)
  );

  line_t lm_in, lm_out;
  logic  lm_changed;
  line_merge u_lm (.line_in(lm_in), .line_out(lm_out), .changed(lm_changed));

  typedef struct packed {
    line_t in_l;
    line_t out_l;
    logic  chg;
  } lm_vec_t;

  lm_vec_t     lm_tab [10];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] tb_lfsr;
  logic [15:0] l0_g;
  board_t      mb;
  board_t      slide_snap;
  board_t      force_board;
  bit          model_over;

  function automatic logic [15:0] ref_step(logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Free-running copy of the random source, reset to the seed
  always @(posedge clk) begin
    if (!reset) tb_lfsr <= 16'hACE1;
    else        tb_lfsr <= ref_step(tb_lfsr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic line_t mk_line(int a, int b, int c, int d);
    line_t l;
    l[0] = tile_t'(a);
    l[1] = tile_t'(b);
    l[2] = tile_t'(c);
    l[3] = tile_t'(d);
    return l;
  endfunction

  // Standard 2048 rule on a list of tiles read from the move edge
  function automatic line_t model_line(line_t in_l);
    int    q[$];
    int    r[$];
    int    i;
    line_t o;
    for (int k = 0; k < N; k++) if (in_l[k] != 0) q.push_back(int'(in_l[k]));
    i = 0;
    while (i < q.size()) begin
      if (i + 1 < q.size() && q[i] == q[i+1]) begin
        r.push_back(q[i] == 15 ? 15 : q[i] + 1);
        i += 2;
      end else begin
        r.push_back(q[i]);
        i += 1;
      end
    end
    o = '0;
    for (int k = 0; k < r.size(); k++) o[k] = tile_t'(r[k]);
    return o;
  endfunction

  // Board position of the p-th tile (from the move edge) of line k
  function automatic void cell_of(int dir, int k, int p, output int r, output int c);
    case (dir)
      0:       begin r = k;         c = N - 1 - p; end
      1:       begin r = k;         c = p;         end
      2:       begin r = p;         c = k;         end
      default: begin r = N - 1 - p; c = k;         end
    endcase
  endfunction

  function automatic board_t model_move(board_t b, int dir);
    board_t o;
    line_t  li, lo;
    int     r, c;
    o = b;
    for (int k = 0; k < N; k++) begin
      for (int p = 0; p < N; p++) begin
        cell_of(dir, k, p, r, c);
        li[p] = b[r][c];
      end
      lo = model_line(li);
      for (int p = 0; p < N; p++) begin
        cell_of(dir, k, p, r, c);
        o[r][c] = lo[p];
      end
    end
    return o;
  endfunction

  function automatic bit model_lost(board_t b);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (b[r][c] == 0) return 1'b0;
        if (c + 1 < N && b[r][c] == b[r][c+1]) return 1'b0;
        if (r + 1 < N && b[r][c] == b[r+1][c]) return 1'b0;
      end
    return 1'b1;
  endfunction

  function automatic int count_val(board_t b, int v);
    int n = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (int'(b[r][c]) == v) n++;
    return n;
  endfunction

  // One spawn pass: scan from the random index, one cell per cycle
  task automatic model_spawn(inout board_t b, inout logic [15:0] l, output int cyc);
    int s;
    s = int'(l[3:0]);
    cyc = 0;
    for (int n = 0; n < 16; n++) begin
      cyc++;
      l = ref_step(l);
      if (b[s/4][s%4] == 0) begin
        b[s/4][s%4] = tile_t'(1);
        return;
      end
      s = (s + 1) % 16;
    end
  endtask

  task automatic drive(input logic [3:0] v);
    gif.mov_right = v[3];
    gif.mov_left  = v[2];
    gif.mov_up    = v[1];
    gif.mov_down  = v[0];
  endtask

  // Press the buttons in mask (bit order right,left,up,down) for hold
  // cycles and count busy cycles over a fixed window
  task automatic press(input logic [3:0] mask, input int hold, output int busy_n);
    @(negedge clk);
    l0_g = tb_lfsr;
    drive(~mask);
    busy_n = 0;
    for (int n = 1; n <= WINDOW; n++) begin
      @(negedge clk);
      if (n == hold) drive(4'hF);
      if (n == 5) slide_snap = gif.matrix;
      if (gif.busy) busy_n++;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    drive(4'hF);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_over = 1'b0;
  endtask

  task automatic start_game(input logic [3:0] mask);
    int          bn, k1, k2;
    logic [15:0] l;
    press(mask, 1, bn);
    mb = '0;
    l = l0_g;
    model_spawn(mb, l, k1);
    model_spawn(mb, l, k2);
    check("start_board", gif.matrix, mb);
    check("start_two_tiles", 64'(count_val(gif.matrix, 1)), 64'd2);
    check("start_busy_cycles", 64'(bn), 64'(k1 + k2 + 1));
    check("start_busy_bound", 64'(bn <= 40), 64'd1);
    $display("start: busy %0d cycles, board %h", bn, gif.matrix);
  endtask

  task automatic do_move(input logic [3:0] mask, input int hold, input int dir);
    board_t      slid, exp_b;
    logic [15:0] l;
    int          k, bn;
    bit          chg;
    press(mask, hold, bn);
    slid = model_move(mb, dir);
    chg  = (slid != mb);
    l = l0_g;
    repeat (4) l = ref_step(l);
    exp_b = slid;
    k = 0;
    if (chg) model_spawn(exp_b, l, k);
    check("slide_result", slide_snap, slid);
    check("move_board", gif.matrix, exp_b);
    check("move_busy_cycles", 64'(bn), chg ? 64'(5 + k) : 64'd5);
    check("move_defeat", 64'(gif.defeat), 64'(model_lost(exp_b)));
    $display("move dir %0d mask %b: busy %0d, board %h", dir, mask, bn, gif.matrix);
    mb = exp_b;
    model_over = model_lost(exp_b);
  endtask

  initial begin
    int   bn, dir;
    logic [3:0] mask;
    bit   rj, seen;
    line_t rl;

    drive(4'hF);
    lm_in = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("reset_matrix", gif.matrix, 64'd0);
      check("reset_flags", {61'd0, gif.busy, gif.defeat, gif.win}, 64'd0);
    end
    $display("reset idle: 100 cycles observed");

    // line_merge vectors
    lm_tab[0] = '{in_l: mk_line(1,1,1,1),   out_l: mk_line(2,2,0,0),  chg: 1'b1};
    lm_tab[1] = '{in_l: mk_line(2,0,2,3),   out_l: mk_line(3,3,0,0),  chg: 1'b1};
    lm_tab[2] = '{in_l: mk_line(1,2,0,0),   out_l: mk_line(1,2,0,0),  chg: 1'b0};
    lm_tab[3] = '{in_l: mk_line(15,15,0,0), out_l: mk_line(15,0,0,0), chg: 1'b1};
    lm_tab[4] = '{in_l: mk_line(0,0,0,0),   out_l: mk_line(0,0,0,0),  chg: 1'b0};
    lm_tab[5] = '{in_l: mk_line(0,0,0,1),   out_l: mk_line(1,0,0,0),  chg: 1'b1};
    lm_tab[6] = '{in_l: mk_line(3,3,3,0),   out_l: mk_line(4,3,0,0),  chg: 1'b1};
    lm_tab[7] = '{in_l: mk_line(2,2,4,4),   out_l: mk_line(3,5,0,0),  chg: 1'b1};
    lm_tab[8] = '{in_l: mk_line(1,2,1,2),   out_l: mk_line(1,2,1,2),  chg: 1'b0};
    lm_tab[9] = '{in_l: mk_line(0,5,0,5),   out_l: mk_line(6,0,0,0),  chg: 1'b1};
    for (int i = 0; i < 10; i++) begin
      lm_in = lm_tab[i].in_l;
      #1;
      check("lm_table_out", lm_out, lm_tab[i].out_l);
      check("lm_table_changed", 64'(lm_changed), 64'(lm_tab[i].chg));
      $display("line_merge vec %0d: in %h out %h changed %b", i, lm_in, lm_out, lm_changed);
    end
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < N; p++) rl[p] = tile_t'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 15));
      lm_in = rl;
      #1;
      check("lm_random_out", lm_out, model_line(rl));
      check("lm_random_changed", 64'(lm_changed), 64'(model_line(rl) != rl));
    end

    // First press starts the game, then a right move
    start_game(4'b1000);
    do_move(4'b1000, 1, 0);
    rj = 1'b1;
    for (int r = 0; r < N; r++) begin
      seen = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (slide_snap[r][c] != 0) seen = 1'b1;
        else if (seen) rj = 1'b0;
      end
    end
    check("right_justified", 64'(rj), 64'd1);

    // Down and left together, held: one left move only
    do_move(4'b0101, 30, 1);

    // Random play
    for (int i = 0; i < 40; i++) begin
      dir  = $urandom_range(0, 3);
      mask = 4'b1000 >> dir;
      mask = mask | (4'($urandom) & (mask - 4'd1));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_move(mask, $urandom_range(1, 8), dir);
      if (model_over) begin
        reset_dut();
        start_game(4'b0001);
      end
    end

    // Full board without pairs: defeat, then presses ignored
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        force_board[r][c] = tile_t'(((r + c) % 2 == 0) ? 1 : 2);
    @(negedge clk);
    force dut.board_q = force_board;
    mb = force_board;
    do_move(4'b0010, 1, 2);
    check("defeat_set", 64'(gif.defeat), 64'd1);
    release dut.board_q;
    press(4'b1000, 1, bn);
    check("lost_ignores_busy", 64'(bn), 64'd0);
    check("lost_holds_board", gif.matrix, force_board);
    check("lost_holds_defeat", 64'(gif.defeat), 64'd1);
    $display("lost: press ignored, busy %0d", bn);
    reset_dut();
    @(negedge clk);
    check("reset_clears_board", gif.matrix, 64'd0);
    check("reset_clears_flags", {61'd0, gif.busy, gif.defeat, gif.win}, 64'd0);

    // A 2048 tile on the board
    start_game(4'b0100);
    force_board = '0;
    force_board[0][3] = tile_t'(11);
    @(negedge clk);
    force dut.board_q = force_board;
    mb = force_board;
    do_move(4'b1000, 1, 0);
    release dut.board_q;
`ifdef WIN_DETECT_EN
    check("win_set", 64'(gif.win), 64'd1);
    press(4'b0100, 1, bn);
    check("won_ignores_busy", 64'(bn), 64'd0);
    check("won_holds_board", gif.matrix, force_board);
    check("won_holds_win", 64'(gif.win), 64'd1);
`else
    check("win_tied_low", 64'(gif.win), 64'd0);
    do_move(4'b0100, 1, 1);
    check("win_still_low", 64'(gif.win), 64'd0);
`endif
    $display("win check: win=%b", gif.win);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have the ports: clk  in  1  single system clock; all logic on rising edge.
REQ-002 The block SHALL have the port: reset  in  1  synchronous, active-low reset.
REQ-003 The block SHALL have the ports: mov_right, mov_left, mov_up, mov_down  in  1 each  raw push-buttons, active-low (1 = released).
REQ-004 The block SHALL have the port: matrix  out  4 bits x [0:3][0:3]  board; cell value n = tile 2^n, 0 = empty.
REQ-005 The block SHALL have the ports: defeat  out  1  game lost; win  out  1  2048 reached; busy  out  1  move/spawn in progress.

Function
REQ-006 A press SHALL be detected on a 1->0 transition of a button against its registered previous value; one event per press.
REQ-007 Simultaneous presses SHALL resolve right > left > up > down; losing presses are discarded.
REQ-008 Presses in any state other than WAIT_START or IDLE SHALL be discarded.
REQ-009 The FSM SHALL have states WAIT_START, IDLE, SLIDE, SPAWN, CHECK, LOST, WON.
REQ-010 In WAIT_START, any press SHALL trigger two SPAWN passes, then go to IDLE, with no slide.
REQ-011 In IDLE, a press SHALL latch the direction and enter SLIDE on the next cycle.
REQ-012 SLIDE SHALL last exactly 4 cycles, processing line k (row for left/right, column for up/down) in cycle k and writing it back at that edge.
REQ-013 Each line SHALL be read in move order: compress toward the move edge, merge equal adjacent pairs once (value n+1, saturating at 15), then re-compress.
REQ-014 If no cell changed during SLIDE, the block SHALL skip SPAWN and go directly to CHECK.
REQ-015 SPAWN SHALL start at cell index lfsr[3:0], scan one cell per cycle with wrap 15->0, write 1 into the first empty cell, and take 1-16 cycles.
REQ-016 The LFSR SHALL be 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, and advance every cycle.
REQ-017 CHECK (1 cycle) SHALL assert defeat and enter LOST when there is no empty cell and no horizontally or vertically adjacent equal pair; otherwise it SHALL enter IDLE.
REQ-018 LOST SHALL hold matrix and defeat until reset.
REQ-019 busy SHALL be 1 in SLIDE, SPAWN and CHECK, and 0 otherwise.

Reset
REQ-020 With reset=0 at a rising edge, the block SHALL clear matrix to all 0, clear defeat, win and busy to 0, set state to WAIT_START, load the LFSR with the seed, and load the button history registers with 1.
REQ-021 Reset mid-SLIDE or mid-SPAWN SHALL abandon the operation; no partial update survives.

Configuration
REQ-022 With WIN_DETECT_EN defined, CHECK SHALL test for any cell == 11 first; if found, win goes to 1 and the FSM enters WON, frozen until reset.
REQ-023 Without WIN_DETECT_EN, win SHALL be tied to 0, WON SHALL be unreachable, and play SHALL continue past 11.

Structure
REQ-024 Package game_pkg SHALL hold: N=4, TILE_W=4, WIN_TILE=11, LFSR_SEED, dir_t enum (RIGHT, LEFT, UP, DOWN), state_t enum, and the line type (4 x TILE_W).
REQ-025 Sub-module line_merge SHALL be purely combinational: 4 tiles in (move-edge first), 4 tiles out, plus a changed flag.
REQ-026 Line gather/scatter per direction and all sequencing SHALL be in game_sequencer.

Verification
REQ-027 Reset release, no press: matrix all 0, busy=0, defeat=0, win=0 held for 100 cycles.
REQ-028 First mov_right pulse: exactly two cells == 1, all others 0; busy returns 0 within 40 cycles of the press.
REQ-029 line_merge unit vectors: [1,1,1,1]->[2,2,0,0]; [2,0,2,3]->[3,3,0,0]; [1,2,0,0]->[1,2,0,0] with changed=0; [15,15,0,0]->[15,0,0,0].
REQ-030 Start then mov_right: every row's nonzero tiles are right-justified and match the reference model; busy holds 1 for exactly 4 SLIDE cycles.
REQ-031 mov_down and mov_left asserted in the same cycle: a left move executes; held buttons produce no repeat.
REQ-032 Board forced full with no pairs via hierarchical deposit, then any press: defeat=1, later presses ignored, reset clears; under WIN_DETECT_EN a forced cell of 11 gives win=1.
